instr_dec_stage: RTL and testbench

INSTR_DEC_STAGE -- requirements
Module: instr_dec_stage

---
 rtl/instr_dec_pkg.sv | 50 +++++
 rtl/instr_fifo.sv | 67 ++++++
 rtl/instr_dec_stage.sv | 168 ++++++++++++++++
 tb/tb_instr_dec_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_dec_pkg.sv
// ---------------------------------------------------------------------------
// instr_dec_pkg : opcode/op constants, instruction layout and FSM state type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package instr_dec_pkg;

   localparam int INSTR_W = 16;

   localparam logic [2:0] OPC_ALU = 3'b101;
   localparam logic [2:0] OPC_MOV = 3'b110;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_CMP = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_MVN = 2'b11;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;

   localparam int OPC_LSB   = 13;
   localparam int OP_LSB    = 11;
   localparam int RN_LSB    = 8;
   localparam int RD_LSB    = 5;
   localparam int SHIFT_LSB = 3;
   localparam int RM_LSB    = 0;
   localparam int IMM8_W    = 8;
   localparam int IMM5_W    = 5;

   // Field order mirrors the bit positions above (MSB first)
   typedef struct packed {
      logic [2:0] opcode;
      logic [1:0] op;
      logic [2:0] rn;
      logic [2:0] rd;
      logic [1:0] shift;
      logic [2:0] rm;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD_A = 2'd1,
      S_RD_B = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// ---------------------------------------------------------------------------
// instr_fifo : power-of-2 instruction buffer with synchronous flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fifo #(
   parameter int DATA       = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush_i,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [DATA-1:0] wdata_i,
   output logic [DATA-1:0] rdata_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]  CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [DATA-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign rdata_o = mem_q[rd_ptr_q];

   // A pop frees the head slot on the same edge, so a push into a full FIFO is safe then
   assign do_push = push_i && (!full_o || pop_i) && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
         else if (!do_push && do_pop) count_q <= count_q - CNT_ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_dec_stage.sv
// ---------------------------------------------------------------------------
// instr_dec_stage : buffered decode stage sequencing register-file reads.
// Optional illegal-opcode drop enabled by macro INSTR_DEC_ILLEGAL_DET_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_dec_stage
   import instr_dec_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [15:0]       in_instr,
   output logic              in_ready,
   input  logic              flush,
   output logic              rf_rd_en,
   output logic              rf_rd_sel,
   output logic [2:0]        readnum,
   output logic [2:0]        writenum,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [2:0]        opcode,
   output logic [1:0]        op,
   output logic [1:0]        ALUop,
   output logic [1:0]        shift,
   output logic [DATA_W-1:0] sximm8,
   output logic [DATA_W-1:0] sximm5
`ifdef INSTR_DEC_ILLEGAL_DET_EN
   ,
   output logic              illegal
`endif
);

   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;
   logic [INSTR_W-1:0] fifo_rdata;
   instr_t             head;

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] cur_q, cur_d;
   instr_t             cur_f, cur_f_d;
   logic               rf_rd_en_q, rf_rd_sel_q, dec_valid_q;
   logic [2:0]         readnum_q, readnum_d;
`ifdef INSTR_DEC_ILLEGAL_DET_EN
   logic               illegal_q, illegal_d;
`endif

   assign in_ready = !fifo_full;

   instr_fifo #(
      .DATA       (INSTR_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush),
      .push_i  (in_valid && in_ready),
      .pop_i   (fifo_pop),
      .wdata_i (in_instr),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head    = instr_t'(fifo_rdata);
   assign cur_f   = instr_t'(cur_q);
   assign cur_f_d = instr_t'(cur_d);

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      fifo_pop = 1'b0;
`ifdef INSTR_DEC_ILLEGAL_DET_EN
      illegal_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               cur_d    = fifo_rdata;
               if (head.opcode == OPC_ALU)
                  state_d = (head.op == OP_MVN) ? S_RD_B : S_RD_A;
               else if (head.opcode == OPC_MOV && head.op == OP_MOV_REG)
                  state_d = S_RD_B;
               else if (head.opcode == OPC_MOV && head.op == OP_MOV_IMM)
                  state_d = S_DONE;
               else begin
`ifdef INSTR_DEC_ILLEGAL_DET_EN
                  cur_d     = cur_q;
                  illegal_d = 1'b1;
`else
                  state_d   = S_DONE;
`endif
               end
            end
         end
         S_RD_A:  state_d = S_RD_B;
         S_RD_B:  state_d = S_DONE;
         S_DONE:  if (dec_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (flush) begin
         state_d  = S_IDLE;
         cur_d    = '0;
         fifo_pop = 1'b0;
`ifdef INSTR_DEC_ILLEGAL_DET_EN
         illegal_d = 1'b0;
`endif
      end

      // Read strobes are registered, so they are computed from the state being entered
      case (state_d)
         S_RD_A:  readnum_d = cur_f_d.rn;
         S_RD_B:  readnum_d = cur_f_d.rm;
         default: readnum_d = 3'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         rf_rd_en_q  <= 1'b0;
         rf_rd_sel_q <= 1'b0;
         readnum_q   <= 3'd0;
         dec_valid_q <= 1'b0;
`ifdef INSTR_DEC_ILLEGAL_DET_EN
         illegal_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         rf_rd_en_q  <= (state_d == S_RD_A) || (state_d == S_RD_B);
         rf_rd_sel_q <= (state_d == S_RD_B);
         readnum_q   <= readnum_d;
         dec_valid_q <= (state_d == S_DONE);
`ifdef INSTR_DEC_ILLEGAL_DET_EN
         illegal_q   <= illegal_d;
`endif
      end
   end

   assign rf_rd_en  = rf_rd_en_q;
   assign rf_rd_sel = rf_rd_sel_q;
   assign readnum   = readnum_q;
   assign dec_valid = dec_valid_q;
`ifdef INSTR_DEC_ILLEGAL_DET_EN
   assign illegal   = illegal_q;
`endif

   assign opcode = cur_f.opcode;
   assign op     = cur_f.op;
   assign ALUop  = cur_f.op;
   assign shift  = cur_f.shift;
   // MOV-imm (and anything decoded like it) targets Rn; ALU and MOV-reg target Rd
   assign writenum = ((cur_f.opcode == OPC_ALU) ||
                      (cur_f.opcode == OPC_MOV && cur_f.op == OP_MOV_REG)) ? cur_f.rd : cur_f.rn;
   assign sximm8 = {{(DATA_W-IMM8_W){cur_q[IMM8_W-1]}}, cur_q[IMM8_W-1:0]};
   assign sximm5 = {{(DATA_W-IMM5_W){cur_q[IMM5_W-1]}}, cur_q[IMM5_W-1:0]};

endmodule

`default_nettype wire

// File: tb/tb_instr_dec_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_dec_stage : directed vectors with a queue-based scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_dec_stage;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic [15:0] in_instr;
   logic        in_ready;
   logic        flush;
   logic        rf_rd_en;
   logic        rf_rd_sel;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        dec_valid;
   logic        dec_ready;
   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [1:0]  ALUop;
   logic [1:0]  shift;
   logic [15:0] sximm8;
   logic [15:0] sximm5;
`ifdef INSTR_DEC_ILLEGAL_DET_EN
   logic        illegal;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [15:0] instr;
      logic [2:0]  wn;
      int          nrd;
      logic [3:0]  r0;
      logic [3:0]  r1;
      logic [15:0] sx8;
      logic [15:0] sx5;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] cap [2];
   int         ncap = 0;

   instr_dec_stage #(.DATA_W(16), .FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .flush     (flush),
      .rf_rd_en  (rf_rd_en),
      .rf_rd_sel (rf_rd_sel),
      .readnum   (readnum),
      .writenum  (writenum),
      .dec_valid (dec_valid),
      .dec_ready (dec_ready),
      .opcode    (opcode),
      .op        (op),
      .ALUop     (ALUop),
      .shift     (shift),
      .sximm8    (sximm8),
      .sximm5    (sximm5)
`ifdef INSTR_DEC_ILLEGAL_DET_EN
      ,
      .illegal   (illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: records register-file reads and compares each accepted decode
   always @(negedge clk) begin
      if (!reset_n || flush) begin
         exp_q.delete();
         ncap = 0;
      end else begin
         if (rf_rd_en) begin
            if (ncap < 2) cap[ncap] = {rf_rd_sel, readnum};
            ncap++;
         end
         if (dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_output", 64'(opcode), 64'hDEAD);
            end else begin
               exp_t e;
               logic [3:0] a0, a1, e0, e1;
               e  = exp_q.pop_front();
               a0 = (ncap > 0) ? cap[0] : 4'h0;
               a1 = (ncap > 1) ? cap[1] : 4'h0;
               e0 = (e.nrd > 0) ? e.r0 : 4'h0;
               e1 = (e.nrd > 1) ? e.r1 : 4'h0;
               check("sb_fields",
                     64'({opcode, op, ALUop, shift, writenum, sximm8, sximm5}),
                     64'({e.instr[15:13], e.instr[12:11], e.instr[12:11], e.instr[4:3],
                          e.wn, e.sx8, e.sx5}));
               check("sb_reads", 64'({4'(ncap), a0, a1}), 64'({4'(e.nrd), e0, e1}));
            end
            ncap = 0;
         end
      end
   end

   task automatic push(input logic [15:0] ins, input logic [2:0] wn, input int nrd,
                       input logic [3:0] r0, input logic [3:0] r1,
                       input logic [15:0] sx8, input logic [15:0] sx5, input bit track);
      int n = 0;
      in_valid = 1'b1;
      in_instr = ins;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("push_timeout", 64'(in_ready), 64'd1);
      else if (track) exp_q.push_back('{ins, wn, nrd, r0, r1, sx8, sx5});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int exp_lat);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dec_valid && n < 30);
      check(name, 64'(n), 64'(exp_lat));
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 16'h0;
      flush     = 1'b0;
      dec_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_dec_valid", 64'(dec_valid), 64'd0);
      check("rst_rf_rd_en", 64'({rf_rd_en, readnum}), 64'd0);
      check("rst_decoded", 64'({opcode, op, writenum, sximm8, sximm5}), 64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      dec_ready = 1'b1;

      // Latency from an empty, idle stage per class
      push(16'hA147, 3'd2, 2, 4'h1, 4'hF, 16'h0047, 16'h0007, 1'b1);   // ADD
      wait_valid("lat_add", 4);
      @(posedge clk); #1;
      push(16'hD285, 3'd2, 0, 4'h0, 4'h0, 16'hFF85, 16'h0005, 1'b1);   // MOV R2,#-123
      wait_valid("lat_mov_imm", 2);
      @(posedge clk); #1;
      push(16'hC571, 3'd3, 1, 4'h9, 4'h0, 16'h0071, 16'hFFF1, 1'b1);   // MOV-reg
      wait_valid("lat_mov_reg", 3);
      @(posedge clk); #1;
      push(16'hBB8E, 3'd4, 1, 4'hE, 4'h0, 16'hFF8E, 16'h000E, 1'b1);   // MVN
      wait_valid("lat_mvn", 3);
      @(posedge clk); #1;

      // Backpressure: three instructions, consumer stalled
      dec_ready = 1'b0;
      push(16'hAE02, 3'd0, 2, 4'h6, 4'hA, 16'h0002, 16'h0002, 1'b1);   // CMP
      push(16'hB7BC, 3'd5, 2, 4'h7, 4'hC, 16'hFFBC, 16'hFFFC, 1'b1);   // AND
      push(16'hD285, 3'd2, 0, 4'h0, 4'h0, 16'hFF85, 16'h0005, 1'b1);
      repeat (4) @(negedge clk);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_dec_valid_held", 64'(dec_valid), 64'd1);
      @(posedge clk);
      #1 dec_ready = 1'b1;
      wait_drain("bp_drain");

      // Flush while in RD_B with one entry buffered
      dec_ready = 1'b0;
      push(16'hA147, 3'd2, 2, 4'h1, 4'hF, 16'h0047, 16'h0007, 1'b1);
      push(16'hC571, 3'd3, 1, 4'h9, 4'h0, 16'h0071, 16'hFFF1, 1'b1);
      @(negedge clk);
      check("fl_rd_a", 64'({rf_rd_en, rf_rd_sel, readnum}), 64'({1'b1, 1'b0, 3'd1}));
      @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("fl_rd_b", 64'({rf_rd_en, rf_rd_sel, readnum}), 64'({1'b1, 1'b1, 3'd7}));
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("fl_after", 64'({in_ready, dec_valid, rf_rd_en}), 64'({1'b1, 1'b0, 1'b0}));
      repeat (3) @(negedge clk);
      check("fl_discarded", 64'({dec_valid, rf_rd_en}), 64'd0);
      @(posedge clk);
      #1 dec_ready = 1'b1;
      push(16'hD285, 3'd2, 0, 4'h0, 4'h0, 16'hFF85, 16'h0005, 1'b1);
      wait_valid("fl_next_decode", 2);
      @(posedge clk); #1;

      // Illegal opcode handling
`ifdef INSTR_DEC_ILLEGAL_DET_EN
      push(16'h0000, 3'd0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      check("ill_c1", 64'({illegal, dec_valid}), 64'd0);
      @(negedge clk);
      check("ill_pulse", 64'({illegal, dec_valid}), 64'({1'b1, 1'b0}));
      @(negedge clk);
      check("ill_end", 64'({illegal, dec_valid}), 64'd0);
      @(posedge clk); #1;
      push(16'hAE02, 3'd0, 2, 4'h6, 4'hA, 16'h0002, 16'h0002, 1'b1);
      wait_valid("ill_next_decode", 4);
`else
      push(16'h0000, 3'd0, 0, 4'h0, 4'h0, 16'h0000, 16'h0000, 1'b1);
      wait_valid("lat_undef_as_mov_imm", 2);
`endif
      @(posedge clk); #1;

      // Asynchronous reset while holding DONE
      dec_ready = 1'b0;
      push(16'hD285, 3'd2, 0, 4'h0, 4'h0, 16'hFF85, 16'h0005, 1'b1);
      wait_valid("rs_reach_done", 2);
      #3 reset_n = 1'b0;
      #1;
      check("rs_async_drop", 64'({dec_valid, in_ready}), 64'({1'b0, 1'b1}));
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1 dec_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rs_fifo_empty", 64'({dec_valid, rf_rd_en, in_ready}), 64'({1'b0, 1'b0, 1'b1}));
      @(posedge clk); #1;
      push(16'hA147, 3'd2, 2, 4'h1, 4'hF, 16'h0047, 16'h0007, 1'b1);
      wait_valid("rs_next_decode", 4);
      wait_drain("final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
